rptr_empty: RTL and testbench

- Read-side pointer and empty-flag stage of the async FIFO, running in the read clock domain.
- Consumes the Gray write pointer `wptr` produced by the write-side stage.
- Synchronizes `wptr` into `rclk`, maintains the Gray read pointer, and generates the memory read address, `rempty`, an occupancy count and an almost-empty flag.
- The read address uses the same GRAYSTYLE1 address mapping as the write side, so both sides address the shared memory consistently.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sync_w2r.sv | 30 +++
 rtl/rptr_empty.sv | 93 +++++++++
 tb/tb_rptr_empty.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the default address width.
// Used by both the read-side and write-side pointer stages.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int GRAY_MAXW    = 32;

  // Width-agnostic: narrower pointers are passed zero-extended and the result truncated.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAXW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Plain flop-chain synchronizer bringing the Gray write pointer into the read clock.
// STAGES edges of latency, synchronous active-high reset, no logic between stages.
module sync_w2r #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer/empty stage of the async FIFO: Gray read pointer, GRAYSTYLE1 address,
// registered empty/almost-empty/occupancy. Sticky underflow flag when RPTR_EMPTY_UNDERFLOW_EN is defined.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rwptr_raw,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rcount,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_TH = PW'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rwptr2;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rcount_q, rcount_d;
  logic              raddrmsb_q, raddrmsb_d;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic [ADDRSIZE:0] rbin, rbnext, wbin;

  sync_w2r #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_sync_w2r (
    .clk_i(rclk),
    .rst_i(rrst),
    .d_i  (rwptr_raw),
    .q_o  (rwptr2)
  );

  always_comb begin
    rbin       = PW'(gray2bin(GRAY_MAXW'(rptr_q)));
    rbnext     = rbin + PW'(rinc & ~rempty_q);
    rptr_d     = PW'(bin2gray(GRAY_MAXW'(rbnext)));
    raddrmsb_d = rptr_d[ADDRSIZE] ^ rptr_d[ADDRSIZE-1];
    rempty_d   = (rptr_d == rwptr2);
    wbin       = PW'(gray2bin(GRAY_MAXW'(rwptr2)));
    rcount_d   = wbin - rbnext;
    raempty_d  = (rcount_d <= AE_TH);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_q     <= '0;
      raddrmsb_q <= 1'b0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      rcount_q   <= '0;
    end else begin
      rptr_q     <= rptr_d;
      raddrmsb_q <= raddrmsb_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      rcount_q   <= rcount_d;
    end
  end

`ifdef RPTR_EMPTY_UNDERFLOW_EN
  logic runderflow_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else if (rinc && rempty_q) begin
      runderflow_q <= 1'b1;
    end
  end

  assign runderflow = runderflow_q;
`else
  assign runderflow = 1'b0;
`endif

  // GRAYSTYLE1: top address bit folds the two Gray MSBs so both sides agree on the mapping.
  assign raddr   = {raddrmsb_q, rptr_q[ADDRSIZE-2:0]};
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rcount  = rcount_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty (ADDRSIZE=4, SYNC_STAGES=2, AEMPTY_THRESH=2).
// A binary-domain reference predicts every output; predictions are queued at drive time and popped after the edge.
module tb_rptr_empty;

  typedef struct packed {
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rcount;
    logic       uf;
  } exp_t;

  logic       rclk;
  logic       rrst;
  logic       rinc;
  logic [4:0] rwptr_raw;
  logic       rempty;
  logic       raempty;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic [4:0] rcount;
  logic       runderflow;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t exp_q[$];

  // reference state
  logic [4:0] m_s1   = '0;
  logic [4:0] m_s2   = '0;
  logic [4:0] m_rbin = '0;
  logic [4:0] m_cnt  = '0;
  logic       m_empty = 1'b1;
  logic       m_ae    = 1'b1;
  logic       m_uf    = 1'b0;
  logic [4:0] wb;

  rptr_empty #(
    .ADDRSIZE     (4),
    .SYNC_STAGES  (2),
    .AEMPTY_THRESH(2)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rinc      (rinc),
    .rwptr_raw (rwptr_raw),
    .rempty    (rempty),
    .raempty   (raempty),
    .raddr     (raddr),
    .rptr      (rptr),
    .rcount    (rcount),
    .runderflow(runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] g2b_m(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [4:0] b2g_m(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  task automatic model_step(output exp_t e);
    logic pop;
    if (rrst) begin
      m_s1 = '0; m_s2 = '0; m_rbin = '0; m_cnt = '0;
      m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    end else begin
      pop = rinc && !m_empty;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
      if (rinc && m_empty) m_uf = 1'b1;
`endif
      m_rbin  = m_rbin + {4'd0, pop};
      m_cnt   = g2b_m(m_s2) - m_rbin;
      m_empty = (m_cnt == 5'd0);
      m_ae    = (m_cnt <= 5'd2);
      m_s2    = m_s1;
      m_s1    = rwptr_raw;
    end
    e.rptr    = b2g_m(m_rbin);
    e.raddr   = {m_rbin[3], e.rptr[2:0]};
    e.rempty  = m_empty;
    e.raempty = m_ae;
    e.rcount  = m_cnt;
    e.uf      = m_uf;
  endtask

  task automatic tick(input logic rst_v, input logic inc_v, input logic [4:0] wb_v);
    exp_t e;
    rrst = rst_v;
    rinc = inc_v;
    wb = wb_v;
    rwptr_raw = b2g_m(wb_v);
    model_step(e);
    exp_q.push_back(e);
    @(posedge rclk);
    #1;
    e = exp_q.pop_front();
    chk("rptr",       32'(rptr),       32'(e.rptr));
    chk("raddr",      32'(raddr),      32'(e.raddr));
    chk("rempty",     32'(rempty),     32'(e.rempty));
    chk("raempty",    32'(raempty),    32'(e.raempty));
    chk("rcount",     32'(rcount),     32'(e.rcount));
    chk("runderflow", 32'(runderflow), 32'(e.uf));
  endtask

  initial begin
    logic       uf_exp;
    logic [4:0] nwb;
    logic       inc;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
    uf_exp = 1'b1;
`else
    uf_exp = 1'b0;
`endif
    rrst = 1'b1; rinc = 1'b1; rwptr_raw = '0; wb = '0;

    // reset with rinc held high
    tick(1, 1, 0);
    tick(1, 1, 0);
    chk("rst_rptr",    32'(rptr),    32'd0);
    chk("rst_raddr",   32'(raddr),   32'd0);
    chk("rst_rempty",  32'(rempty),  32'd1);
    chk("rst_raempty", 32'(raempty), 32'd1);
    chk("rst_rcount",  32'(rcount),  32'd0);

    // fill: bin 2, visible at the 3rd edge
    tick(0, 0, 2);
    chk("fill_e1_empty", 32'(rempty), 32'd1);
    tick(0, 0, 2);
    chk("fill_e2_empty", 32'(rempty), 32'd1);
    tick(0, 0, 2);
    chk("fill_empty", 32'(rempty),  32'd0);
    chk("fill_cnt2",  32'(rcount),  32'd2);
    chk("fill_ae2",   32'(raempty), 32'd1);
    repeat (3) tick(0, 0, 3);
    chk("fill_cnt3", 32'(rcount),  32'd3);
    chk("fill_ae3",  32'(raempty), 32'd0);

    // drain three, fourth pop ignored
    tick(0, 1, 3);
    chk("pop1_rptr", 32'(rptr), 32'h01); chk("pop1_raddr", 32'(raddr), 32'd1);
    tick(0, 1, 3);
    chk("pop2_rptr", 32'(rptr), 32'h03); chk("pop2_raddr", 32'(raddr), 32'd3);
    tick(0, 1, 3);
    chk("pop3_rptr", 32'(rptr), 32'h02); chk("pop3_raddr", 32'(raddr), 32'd2);
    chk("pop3_empty", 32'(rempty), 32'd1);
    tick(0, 1, 3);
    chk("pop4_hold", 32'(rptr), 32'h02);

    // wrap: bring read pointer to bin 15 with write at 17, then pop across the boundary
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 16);
    chk("full_cnt", 32'(rcount), 32'd16);
    repeat (15) tick(0, 1, 17);
    chk("pre_wrap_rptr",  32'(rptr),  32'h08);
    chk("pre_wrap_raddr", 32'(raddr), 32'd8);
    tick(0, 1, 17);
    chk("wrap_rptr",  32'(rptr),    32'h18);
    chk("wrap_raddr", 32'(raddr),   32'd0);
    chk("wrap_cnt",   32'(rcount),  32'd1);
    chk("wrap_ae",    32'(raempty), 32'd1);

    // simultaneous write advance and pop leaves count unchanged
    repeat (3) tick(0, 0, 21);
    chk("sim_cnt_pre", 32'(rcount), 32'd5);
    tick(0, 0, 22);
    tick(0, 0, 22);
    tick(0, 1, 22);
    chk("sim_cnt", 32'(rcount), 32'd5);
    tick(1, 0, 0);
    chk("rst2_rptr",    32'(rptr),    32'd0);
    chk("rst2_raddr",   32'(raddr),   32'd0);
    chk("rst2_rempty",  32'(rempty),  32'd1);
    chk("rst2_raempty", 32'(raempty), 32'd1);
    chk("rst2_rcount",  32'(rcount),  32'd0);

    // underflow: pop while empty, then data arrives
    tick(0, 1, 0);
    repeat (3) tick(0, 0, 1);
    chk("uf_sticky", 32'(runderflow), 32'(uf_exp));
    tick(1, 0, 0);
    chk("uf_rst", 32'(runderflow), 32'd0);

    // random traffic, write side never overfills
    nwb = 5'd0;
    for (int i = 0; i < 300; i++) begin
      if ((5'(nwb - m_rbin) < 5'd16) && ($urandom_range(0, 2) != 0)) nwb = nwb + 5'd1;
      inc = ($urandom_range(0, 1) == 1);
      tick(0, inc, nwb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
